// File: rtl/beep_sequencer.sv
// Fixed-priority beeper sequencer: grants key/chime/alarm patterns and drives
// the 512 Hz / 1 kHz tone enables with tick-timed on/off phases.
`timescale 1ns/1ps
module beep_sequencer #(
  parameter int TW          = 8,
  parameter int KEY_TICKS   = 5,
  parameter int ON_TICKS    = 20,
  parameter int OFF_TICKS   = 30,
  parameter int CHIME_BEEPS = 3,
  parameter int ALARM_MAX   = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       req_key,
  input  logic       req_chime,
  input  logic       req_alarm,
  input  logic       stop,
  output logic       open512,
  output logic       open1k,
  output logic       busy,
  output logic [1:0] src,
  output logic       done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ON   = 2'd1;
  localparam logic [1:0] S_OFF  = 2'd2;

  localparam logic [1:0] SRC_NONE  = 2'd0;
  localparam logic [1:0] SRC_KEY   = 2'd1;
  localparam logic [1:0] SRC_CHIME = 2'd2;
  localparam logic [1:0] SRC_ALARM = 2'd3;

  localparam logic [TW-1:0] KEY_LIM   = TW'(KEY_TICKS);
  localparam logic [TW-1:0] ON_LIM    = TW'(ON_TICKS);
  localparam logic [TW-1:0] OFF_LIM   = TW'(OFF_TICKS);
  localparam logic [3:0]    CHIME_LIM = 4'(CHIME_BEEPS);
  localparam logic [3:0]    ALARM_LIM = 4'(ALARM_MAX);

  logic [1:0]    state, state_n, src_n, top;
  logic [TW-1:0] tcnt, tcnt_n, tcnt_inc, phase_lim;
  logic [3:0]    bcnt, bcnt_n, beeps_lim;
  logic          pend_chime, pend_alarm, pc_n, pa_n, done_n, grant;
  logic          alarm_rq, chime_rq;

  assign busy = (state != S_IDLE);

  always_comb begin
    // stop beats a same-cycle alarm request, latched or fresh
    alarm_rq  = (req_alarm | pend_alarm) & ~stop;
    chime_rq  = req_chime | pend_chime;
    top       = alarm_rq ? SRC_ALARM : chime_rq ? SRC_CHIME :
                req_key  ? SRC_KEY   : SRC_NONE;
    phase_lim = (state == S_OFF) ? OFF_LIM : (src == SRC_KEY) ? KEY_LIM : ON_LIM;
    beeps_lim = (src == SRC_CHIME) ? CHIME_LIM : ALARM_LIM;
    tcnt_inc  = tcnt + 1'b1;
    state_n   = state;
    src_n     = src;
    tcnt_n    = tcnt;
    bcnt_n    = bcnt;
    done_n    = 1'b0;
    grant     = 1'b0;

    if (state == S_IDLE) begin
      grant = (top != SRC_NONE);
    end else if (src == SRC_ALARM && stop) begin
      state_n = S_IDLE;
      src_n   = SRC_NONE;
      done_n  = 1'b1;
    end else if (top > src) begin
      // key can never outrank an active source, so busy drops req_key here
      grant = 1'b1;
    end else if (tick) begin
      if (tcnt_inc == phase_lim) begin
        tcnt_n = '0;
        if (state == S_ON) begin
          bcnt_n = bcnt + 4'd1;
          if (src == SRC_KEY || bcnt_n == beeps_lim) begin
            state_n = S_IDLE;
            src_n   = SRC_NONE;
            done_n  = 1'b1;
          end else begin
            state_n = S_OFF;
          end
        end else begin
          state_n = S_ON;
        end
      end else begin
        tcnt_n = tcnt_inc;
      end
    end

    if (grant) begin
      state_n = S_ON;
      src_n   = top;
      tcnt_n  = '0;
      bcnt_n  = '0;
    end

    pc_n = (pend_chime | req_chime) & ~(grant && top == SRC_CHIME);
    pa_n = (pend_alarm | req_alarm) & ~stop & ~(grant && top == SRC_ALARM);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      src        <= SRC_NONE;
      tcnt       <= '0;
      bcnt       <= '0;
      pend_chime <= 1'b0;
      pend_alarm <= 1'b0;
      open512    <= 1'b0;
      open1k     <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      src        <= src_n;
      tcnt       <= tcnt_n;
      bcnt       <= bcnt_n;
      pend_chime <= pc_n;
      pend_alarm <= pa_n;
      done       <= done_n;
      // enables follow the next state so preemption swaps tones without a gap
      open512    <= (state_n == S_ON) && (src_n == SRC_CHIME);
      open1k     <= (state_n == S_ON) && (src_n == SRC_KEY || src_n == SRC_ALARM);
    end
  end

endmodule

// File: tb/tb_beep_sequencer.sv
// Bench for beep_sequencer: directed scenarios then random requests, each
// cycle compared against a tick-position model of the beep patterns.
`timescale 1ns/1ps
module tb_beep_sequencer;

  localparam int KT = 2, ONT = 3, OFFT = 2, CB = 3, AM = 4;

  logic clk = 1'b0, rst = 1'b1, tick = 1'b0;
  logic req_key = 1'b0, req_chime = 1'b0, req_alarm = 1'b0, stop = 1'b0;
  logic open512, open1k, busy, done;
  logic [1:0] src;

  int n_checks = 0, n_pass = 0, cyc = 0;

  // model: active source, ticks elapsed since grant, pending latches
  int m_src = 0, m_t = 0;
  bit m_pa = 0, m_pc = 0, m_done = 0;

  beep_sequencer #(.TW(8), .KEY_TICKS(KT), .ON_TICKS(ONT), .OFF_TICKS(OFFT),
                   .CHIME_BEEPS(CB), .ALARM_MAX(AM)) dut (
    .clk(clk), .rst(rst), .tick(tick), .req_key(req_key), .req_chime(req_chime),
    .req_alarm(req_alarm), .stop(stop), .open512(open512), .open1k(open1k),
    .busy(busy), .src(src), .done(done));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic int total(input int s);
    if (s == 1) return KT;
    if (s == 2) return (CB - 1) * (ONT + OFFT) + ONT;
    return (AM - 1) * (ONT + OFFT) + ONT;
  endfunction

  task automatic model_reset();
    m_src = 0; m_t = 0; m_pa = 0; m_pc = 0; m_done = 0;
  endtask

  task automatic model_step(input bit tk, input bit rk, input bit rc, input bit ra, input bit st);
    int want;
    bit g;
    g = 0;
    m_done = 0;
    want = ((ra || m_pa) && !st) ? 3 : (rc || m_pc) ? 2 : (rk && m_src == 0) ? 1 : 0;
    if (m_src == 3 && st) begin
      m_src = 0; m_done = 1;
    end else if (want > m_src) begin
      m_src = want; m_t = 0; g = 1;
    end else if (m_src != 0 && tk) begin
      m_t++;
      if (m_t == total(m_src)) begin m_src = 0; m_done = 1; end
    end
    m_pa = (m_pa || ra) && !st && !(g && want == 3);
    m_pc = (m_pc || rc) && !(g && want == 2);
  endtask

  task automatic check_outputs();
    bit on;
    on = (m_src == 1) || (m_src >= 2 && (m_t % (ONT + OFFT)) < ONT);
    chk("open512", open512, int'(on && m_src == 2));
    chk("open1k",  open1k,  int'(on && (m_src == 1 || m_src == 3)));
    chk("busy",    busy,    int'(m_src != 0));
    chk("src",     src,     m_src);
    chk("done",    done,    int'(m_done));
  endtask

  task automatic step(input bit rk, input bit rc, input bit ra, input bit st);
    req_key = rk; req_chime = rc; req_alarm = ra; stop = st;
    tick = (cyc % 4 == 3);
    model_step(tick, rk, rc, ra, st);
    @(posedge clk); #1;
    check_outputs();
    cyc++;
    req_key = 0; req_chime = 0; req_alarm = 0; stop = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_open512", open512, 0);
    chk("rst_open1k",  open1k,  0);
    chk("rst_busy",    busy,    0);
    chk("rst_src",     src,     0);
    chk("rst_done",    done,    0);
    rst = 0;

    // key click
    step(1, 0, 0, 0);
    chk("key_open1k", open1k, 1);
    chk("key_src",    src,    1);
    idle(14);

    // full chime
    step(0, 1, 0, 0);
    chk("chime_open512", open512, 1);
    idle(60);

    // full alarm, self-terminating
    step(0, 0, 1, 0);
    idle(80);

    // alarm stopped in its second gap
    step(0, 0, 1, 0);
    for (int i = 0; i < 100 && m_t < 2 * ONT + OFFT; i++) step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("off2_open1k", open1k, 0);
    chk("off2_busy",   busy,   1);
    step(0, 0, 0, 1);
    chk("stop_done", done, 1);
    chk("stop_busy", busy, 0);
    idle(6);

    // chime preempted by alarm, chime not resumed
    step(0, 1, 0, 0);
    idle(6);
    step(0, 0, 1, 0);
    chk("pre_src",     src,     3);
    chk("pre_open512", open512, 0);
    chk("pre_open1k",  open1k,  1);
    idle(90);
    chk("pre_idle", busy, 0);

    // alarm active, chime + key requested: key dropped, chime follows alarm
    step(0, 0, 1, 0);
    idle(5);
    step(1, 1, 0, 0);
    chk("pend_src", src, 3);
    idle(140);

    // stop with alarm request in IDLE
    step(0, 0, 1, 1);
    chk("stopreq_busy", busy, 0);
    idle(8);

    // async reset mid-ON
    step(1, 0, 0, 0);
    idle(2);
    rst = 1;
    #1;
    chk("arst_open1k", open1k, 0);
    chk("arst_busy",   busy,   0);
    chk("arst_src",    src,    0);
    model_reset();
    @(posedge clk); #1;
    rst = 0;
    idle(3);

    for (int i = 0; i < 2500; i++)
      step($urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 59) == 0, $urandom_range(0, 29) == 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/beep_sequencer.md
# beep_sequencer

Sequences and arbitrates the timer's beeper. Three event sources request beep patterns: key click, chime and alarm. The block grants one source at a time by fixed priority and drives the beeper tone enables `open512`/`open1k` with a timed on/off pattern. It sits between the timer/keypad control logic and the beeper, and is clocked by the system `clk`. All pattern timing is counted in `tick` strobes.

## Interface
Parameters:
- `TW`, 8 — width of the tick counter.
- `KEY_TICKS`, 5 — on-time of the key click, in ticks (1k tone, single beep).
- `ON_TICKS`, 20 — on-time per beep for chime and alarm, in ticks.
- `OFF_TICKS`, 30 — gap between beeps for chime and alarm, in ticks.
- `CHIME_BEEPS`, 3 — number of beeps in a chime (512 tone).
- `ALARM_MAX`, 10 — maximum number of alarm beeps (1k tone) before self-termination.

Ports:
- `clk`  in  1 — system clock, single clock domain.
- `rst`  in  1 — asynchronous, active-high reset.
- `tick`  in  1 — one-cycle timebase strobe.
- `req_key`  in  1 — one-cycle key-click request.
- `req_chime`  in  1 — one-cycle chime request.
- `req_alarm`  in  1 — one-cycle alarm request.
- `stop`  in  1 — one-cycle alarm cancel.
- `open512`  out  1 — enable for the 512 Hz tone; registered.
- `open1k`  out  1 — enable for the 1 kHz tone; registered; never high together with `open512`.
- `busy`  out  1 — a pattern is active (state is not IDLE).
- `src`  out  2 — active source: 0 = none, 1 = key, 2 = chime, 3 = alarm.
- `done`  out  1 — one-cycle pulse when a pattern ends by completing or by `stop`. Not pulsed on preemption.

## Operation
- States:
  - IDLE — no pattern active.
  - ON — tone enabled per `src`: key → `open1k`; chime → `open512`; alarm → `open1k`.
  - OFF — both tone enables low.
- Pending latches `pend_chime` and `pend_alarm`:
  - Set by their request pulses.
  - Cleared when that source is granted.
  - `stop` clears `pend_alarm`.
- Key requests are not latched. A `req_key` arriving while `busy` is dropped.
- Priority: alarm (3) > chime (2) > key (1).
- From IDLE, the highest pending or present request is granted:
  - Enter ON.
  - Load `src`.
  - Clear the tick counter and the beep counter.
- Preemption:
  - In ON or OFF, a request of strictly higher priority than `src` restarts the FSM in ON with the new source.
  - Counters are cleared; no `done` pulse.
  - The preempted chime is discarded, not resumed.
  - Equal or lower-priority chime/alarm requests stay pending.
- Tick counter:
  - Increments on `tick` in ON and OFF.
  - A phase ends on the tick that brings the count to its limit; the counter then clears.
  - Limits: key ON = `KEY_TICKS`; otherwise ON = `ON_TICKS`, OFF = `OFF_TICKS`.
- Beep counter increments at the end of each ON phase.
- Pattern ends at the end of the ON phase where:
  - key: always (first ON);
  - chime: beep count reaches `CHIME_BEEPS`;
  - alarm: beep count reaches `ALARM_MAX`.
- At pattern end: go to IDLE, pulse `done`, set `src` to 0. No trailing OFF gap.
- `stop` while `src` = 3:
  - Go to IDLE immediately, pulse `done`, drop both tone enables.
  - `stop` has no effect on an active key or chime.
- Simultaneous events:
  - `stop` and `req_alarm` in the same cycle: `stop` wins; the alarm is not started or latched.
  - A pattern end in the same cycle as a pending request: enter IDLE; the request is granted on the following cycle.
- Counter widths:
  - Tick counter is `TW` bits; every tick parameter must be less than 2^`TW`.
  - Beep counter is 4 bits; `CHIME_BEEPS` and `ALARM_MAX` must be between 1 and 15.

## Timing
- Reset values: state IDLE, `open512`=0, `open1k`=0, `busy`=0, `src`=0, `done`=0, pend latches 0, counters 0.
- Reset asserted mid-pattern: outputs go low asynchronously; all pending requests are lost.
- Grant latency: a request sampled at edge n makes `busy`, `src` and the tone enable high after edge n (one cycle).
  - Exception: a request arriving while a pattern is ending is granted at edge n+1.
- A tick sampled on the grant edge is not counted.
- ON phase length: exactly the limit count of ticks after entry. The enable falls on the edge that samples the final tick.
- The `done` pulse is coincident with `busy` falling.
- Preemption takes effect on the edge that samples the higher-priority request. The tone switches with no intervening low cycle.

## Test plan
Bench parameters: `KEY_TICKS`=2, `ON_TICKS`=3, `OFF_TICKS`=2, `CHIME_BEEPS`=3, `ALARM_MAX`=4, and `tick` every 4 cycles.
- `req_key` in IDLE → `open1k` high for 2 ticks, `src`=1, one `done`, and `open512` never high.
- `req_chime` → `open512` pattern on3/off2/on3/off2/on3 (in ticks), then `done` and `busy` low. `open1k` stays 0 throughout.
- `req_alarm` with no `stop` → 4 beeps of `open1k` then self-terminates. Repeat and assert `stop` during the 2nd OFF → immediate IDLE and `done`.
- Chime active, then `req_alarm` → `src` switches 2→3 on the next edge, with `open512` falling and `open1k` rising on the same edge. After the alarm completes, FSM returns to IDLE with no chime resumed.
- Alarm active, then `req_chime` and `req_key` → key dropped. Chime starts one cycle after the alarm's `done`.
- `rst` asserted mid-ON → all outputs 0 immediately. `stop` together with `req_alarm` in IDLE → no activity.
